// File: rtl/video_vga_pkg.sv
// Shared types and default timing for the VGA horizontal timing generator.
package video_vga_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    localparam int DEF_HPERIOD     = 896;
    localparam int DEF_HSYNC_END   = 106;
    localparam int DEF_SCANOUT_BEG = 156;
    localparam int DEF_SCANOUT_LEN = 720;

    // A TV line start is in phase when loading resync_val would not move the count.
    function automatic logic is_in_phase(input logic [31:0] hcount,
                                         input logic [31:0] resync_val,
                                         input logic        line_half);
        return (hcount == resync_val - 32'd1) && !line_half;
    endfunction

endpackage

// File: rtl/video_vga_lock_mon.sv
// Lock monitor: declares lock after LOCK_CNT in-phase TV line starts, drops it on a
// phase error or after MISS_LINES VGA lines without any TV line start.
module video_vga_lock_mon
    import video_vga_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int MISS_LINES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hsync_start,
    input  logic in_phase,
    input  logic wrap,
    output logic locked
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int SW = $clog2(MISS_LINES + 1);

    lock_state_t     state_reg;
    logic [MW-1:0]   match_cnt_reg;
    logic [SW-1:0]   miss_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= UNLOCKED;
            match_cnt_reg <= '0;
            miss_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                UNLOCKED: begin
                    miss_cnt_reg <= '0;
                    if (hsync_start) begin
                        if (!in_phase) begin
                            match_cnt_reg <= '0;
                        end else if (match_cnt_reg == MW'(LOCK_CNT - 1)) begin
                            state_reg     <= LOCKED;
                            match_cnt_reg <= '0;
                        end else begin
                            match_cnt_reg <= match_cnt_reg + MW'(1);
                        end
                    end
                end
                LOCKED: begin
                    // A TV line start always clears the miss count, even on a wrap cycle.
                    if (hsync_start) begin
                        miss_cnt_reg <= '0;
                        if (!in_phase) begin
                            state_reg <= UNLOCKED;
                        end
                    end else if (wrap) begin
                        if (miss_cnt_reg == SW'(MISS_LINES - 1)) begin
                            state_reg    <= UNLOCKED;
                            miss_cnt_reg <= '0;
                        end else begin
                            miss_cnt_reg <= miss_cnt_reg + SW'(1);
                        end
                    end
                end
                default: state_reg <= UNLOCKED;
            endcase
        end
    end

    assign locked = (state_reg == LOCKED);

endmodule

// File: rtl/video_vga_hsync_gen.sv
// VGA horizontal timing at twice the TV line rate, slaved to the TV hsync_start pulse.
// Produces sync, scanout strobes, half-line phase and a lock indication.
module video_vga_hsync_gen
    import video_vga_pkg::*;
#(
    parameter int CW          = 10,
    parameter int HPERIOD     = DEF_HPERIOD,
    parameter int RESYNC_VAL  = 2,
    parameter int HSYNC_END   = DEF_HSYNC_END,
    parameter int SCANOUT_BEG = DEF_SCANOUT_BEG,
    parameter int SCANOUT_LEN = DEF_SCANOUT_LEN,
    parameter bit SYNC_NEG    = 1'b0,
    parameter int LOCK_CNT    = 4,
    parameter int MISS_LINES  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hsync_start,
    output logic          vga_hsync,
    output logic          scanout_start,
    output logic          scanout_active,
    output logic          line_half,
    output logic          locked,
    output logic [CW-1:0] hpos
);

    localparam logic [CW-1:0] HMAX   = CW'(HPERIOD - 1);
    localparam logic [CW-1:0] RESYNC = CW'(RESYNC_VAL);
    localparam logic [CW-1:0] HS_END = CW'(HSYNC_END);
    localparam logic [CW-1:0] SO_BEG = CW'(SCANOUT_BEG);
    localparam logic [CW-1:0] SO_END = CW'(SCANOUT_BEG + SCANOUT_LEN);

    logic [CW-1:0] hcount_reg, hcount_next;
    logic          line_half_reg, line_half_next;
    logic          sync_reg, scanout_start_reg, scanout_active_reg;
    logic          wrap, in_phase, out_phase;

    always_comb begin
        wrap           = (hcount_reg == HMAX);
        in_phase       = hsync_start && is_in_phase(32'(hcount_reg), 32'(RESYNC_VAL), line_half_reg);
        out_phase      = hsync_start && !in_phase;
        hcount_next    = hcount_reg + CW'(1);
        line_half_next = line_half_reg;
        // The TV line start takes priority over the VGA wrap.
        if (hsync_start) begin
            hcount_next    = RESYNC;
            line_half_next = 1'b0;
        end else if (wrap) begin
            hcount_next    = '0;
            line_half_next = !line_half_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_reg         <= '0;
            line_half_reg      <= 1'b0;
            sync_reg           <= 1'b0;
            scanout_start_reg  <= 1'b0;
            scanout_active_reg <= 1'b0;
        end else begin
            hcount_reg        <= hcount_next;
            line_half_reg     <= line_half_next;
            scanout_start_reg <= (hcount_reg == SO_BEG);

            // Sync only starts on count 0, so a load that jumps over 0 skips the pulse.
            if (hcount_reg == '0) begin
                sync_reg <= 1'b1;
            end else if (hcount_reg == HS_END) begin
                sync_reg <= 1'b0;
            end

            if (out_phase) begin
                scanout_active_reg <= 1'b0;
            end else if (hcount_reg == SO_BEG) begin
                scanout_active_reg <= 1'b1;
            end else if (hcount_reg == SO_END) begin
                scanout_active_reg <= 1'b0;
            end
        end
    end

    video_vga_lock_mon #(
        .LOCK_CNT   (LOCK_CNT),
        .MISS_LINES (MISS_LINES)
    ) u_lock_mon (
        .clk         (clk),
        .rst_n       (rst_n),
        .hsync_start (hsync_start),
        .in_phase    (in_phase),
        .wrap        (wrap),
        .locked      (locked)
    );

    assign hpos           = hcount_reg;
    assign line_half      = line_half_reg;
    assign vga_hsync      = sync_reg ^ SYNC_NEG;
    assign scanout_start  = scanout_start_reg;
    assign scanout_active = scanout_active_reg;

endmodule

// File: tb/tb_video_vga_hsync_gen.sv
// Bench for video_vga_hsync_gen: positional model of the line timing checked every
// cycle on two instances (positive and negative sync), plus directed literal checks.
module tb_video_vga_hsync_gen;

    localparam int P     = 896;
    localparam int R     = 2;
    localparam int HE    = 106;
    localparam int SB    = 156;
    localparam int SL    = 720;
    localparam int LOCKN = 4;
    localparam int MISSN = 4;

    logic       clk;
    logic       rst_n;
    logic       hsync_start;
    logic       vga_hsync, scanout_start, scanout_active, line_half, locked;
    logic [9:0] hpos;
    logic       vga_hsync_n, scanout_start_n, scanout_active_n, line_half_n, locked_n;
    logic [9:0] hpos_n;

    int checks   = 0;
    int failures = 0;

    video_vga_hsync_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hsync_start    (hsync_start),
        .vga_hsync      (vga_hsync),
        .scanout_start  (scanout_start),
        .scanout_active (scanout_active),
        .line_half      (line_half),
        .locked         (locked),
        .hpos           (hpos)
    );

    video_vga_hsync_gen #(.SYNC_NEG(1'b1)) dut_n (
        .clk            (clk),
        .rst_n          (rst_n),
        .hsync_start    (hsync_start),
        .vga_hsync      (vga_hsync_n),
        .scanout_start  (scanout_start_n),
        .scanout_active (scanout_active_n),
        .line_half      (line_half_n),
        .locked         (locked_n),
        .hpos           (hpos_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position is the unwrapped distance travelled since the last load (or reset);
    // hpos and line_half follow from it by plain division.
    int m_u;
    bit m_sync, m_start, m_act, m_locked;
    int m_consec, m_wraps;
    int mp;
    bit mh, mip;

    function automatic int exp_pos();
        return m_u % P;
    endfunction
    function automatic int exp_half();
        return (m_u / P) % 2;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_u <= 0; m_sync <= 0; m_start <= 0; m_act <= 0;
            m_locked <= 0; m_consec <= 0; m_wraps <= 0;
        end else begin
            mp  = m_u % P;
            mh  = ((m_u / P) % 2) != 0;
            mip = hsync_start && (mp == R - 1) && !mh;
            m_u     <= hsync_start ? R : m_u + 1;
            m_start <= (mp == SB);
            if (mp == 0)       m_sync <= 1;
            else if (mp == HE) m_sync <= 0;
            if (hsync_start && !mip) m_act <= 0;
            else if (mp == SB)       m_act <= 1;
            else if (mp == SB + SL)  m_act <= 0;
            if (hsync_start) begin
                m_wraps <= 0;
                if (!mip) begin
                    m_consec <= 0;
                    m_locked <= 0;
                end else if (!m_locked) begin
                    if (m_consec + 1 == LOCKN) begin
                        m_locked <= 1;
                        m_consec <= 0;
                    end else begin
                        m_consec <= m_consec + 1;
                    end
                end
            end else if (mp == P - 1 && m_locked) begin
                if (m_wraps + 1 == MISSN) begin
                    m_locked <= 0;
                    m_wraps  <= 0;
                end else begin
                    m_wraps <= m_wraps + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("hpos", int'(hpos), exp_pos());
            chk("line_half", int'(line_half), exp_half());
            chk("vga_hsync", int'(vga_hsync), int'(m_sync));
            chk("scanout_start", int'(scanout_start), int'(m_start));
            chk("scanout_active", int'(scanout_active), int'(m_act));
            chk("locked", int'(locked), int'(m_locked));
            chk("neg_vga_hsync", int'(vga_hsync_n), int'(!m_sync));
            chk("neg_hpos", int'(hpos_n), exp_pos());
            chk("neg_active", int'(scanout_active_n), int'(m_act));
            chk("neg_start", int'(scanout_start_n), int'(m_start));
            chk("neg_half", int'(line_half_n), exp_half());
            chk("neg_locked", int'(locked_n), int'(m_locked));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int p, input int h);
        int n;
        n = 0;
        while (!(exp_pos() == p && (h < 0 || exp_half() == h)) && n < 5000) begin
            step();
            n++;
        end
        if (n >= 5000) begin
            checks++;
            failures++;
            $display("FAIL wait_pos timeout actual=none expected=pos %0d at %0t", p, $time);
        end
    endtask

    task automatic pulse();
        hsync_start = 1'b1;
        step();
        hsync_start = 1'b0;
    endtask

    task automatic window(input int n, output int hs, output int hsn_low, output int ss, output int act);
        hs = 0; hsn_low = 0; ss = 0; act = 0;
        repeat (n) begin
            @(negedge clk);
            hs      += int'(vga_hsync);
            hsn_low += int'(!vga_hsync_n);
            ss      += int'(scanout_start);
            act     += int'(scanout_active);
        end
        step();
    endtask

    initial begin
        int hs, hsn, ss, act;
        rst_n       = 1'b0;
        hsync_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hpos", int'(hpos), 0);
        chk("rst_half", int'(line_half), 0);
        chk("rst_hsync", int'(vga_hsync), 0);
        chk("rst_hsync_neg", int'(vga_hsync_n), 1);
        chk("rst_start", int'(scanout_start), 0);
        chk("rst_active", int'(scanout_active), 0);
        chk("rst_locked", int'(locked), 0);
        rst_n = 1'b1;
        step();
        chk("first_count", int'(hpos), 1);

        // Free run: three lines measured from position 10 of each line.
        for (int w = 0; w < 3; w++) begin
            wait_pos(10, -1);
            chk("free_half", int'(line_half), w % 2);
            window(P, hs, hsn, ss, act);
            chk("free_hsync_width", hs, HE);
            chk("free_hsync_neg_low", hsn, HE);
            chk("free_scan_start", ss, 1);
            chk("free_active_len", act, SL);
        end

        // Acquire lock with in-phase pulses every two VGA lines.
        for (int i = 1; i <= LOCKN; i++) begin
            wait_pos(1, 0);
            pulse();
            chk("acq_hpos", int'(hpos), 2);
            chk("acq_locked", int'(locked), (i == LOCKN) ? 1 : 0);
        end

        // Phase jump while locked.
        wait_pos(500, 0);
        chk("jump_pre_active", int'(scanout_active), 1);
        pulse();
        chk("jump_hpos", int'(hpos), 2);
        chk("jump_half", int'(line_half), 0);
        chk("jump_active", int'(scanout_active), 0);
        chk("jump_locked", int'(locked), 0);
        window(880, hs, hsn, ss, act);
        chk("jump_no_sync", hs, 0);

        // Relock, then stop the TV sync.
        for (int i = 1; i <= LOCKN; i++) begin
            wait_pos(1, 0);
            pulse();
        end
        chk("relock", int'(locked), 1);
        for (int w = 1; w <= MISSN; w++) begin
            wait_pos(P - 1, -1);
            step();
            chk("miss_locked", int'(locked), (w < MISSN) ? 1 : 0);
            chk("miss_wrap_hpos", int'(hpos), 0);
        end

        // TV line start on the wrap cycle.
        wait_pos(P - 1, 0);
        pulse();
        chk("edge_hpos", int'(hpos), 2);
        chk("edge_half", int'(line_half), 0);

        // Reset in the middle of scanout.
        wait_pos(400, -1);
        chk("pre_rst_active", int'(scanout_active), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_hpos", int'(hpos), 0);
        chk("mid_rst_active", int'(scanout_active), 0);
        chk("mid_rst_half", int'(line_half), 0);
        chk("mid_rst_hsync_neg", int'(vga_hsync_n), 1);
        chk("mid_rst_locked", int'(locked), 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("restart_hpos", int'(hpos), 1);
        repeat (900) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
